// File: rtl/fetch_ref_chroma_load_pkg.sv
// Shared constants for the chroma reference row-buffer fill stage:
// FSM state encodings and the beat/row pixel geometry.
package fetch_ref_chroma_load_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int BEATS_PER_ROW = 3;
    localparam int BEAT_PIX      = 16;
    localparam int ROW_PIX       = 48;

endpackage

// File: rtl/fetch_row_packer.sv
// Packs three 16-pixel beats into one 48-pixel row word and drives the
// registered row-buffer write port one cycle after the third beat.
module fetch_row_packer
    import fetch_ref_chroma_load_pkg::*;
#(
    parameter int PIXEL_W = 8,
    parameter int ADDR_W  = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          beat_valid,
    input  logic [BEAT_PIX*PIXEL_W-1:0]   beat_data,
    input  logic [ADDR_W-1:0]             row_addr,
    output logic                          row_last,
    output logic                          wr_en,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [ROW_PIX*PIXEL_W-1:0]    wr_data
);

    localparam int SLOT_W = BEAT_PIX * PIXEL_W;

    logic [1:0]                 beat_cnt;
    logic [ROW_PIX*PIXEL_W-1:0] pack;

    assign row_last = beat_valid && (beat_cnt == 2'(BEATS_PER_ROW - 1));

    // The last slot bypasses the pack register so the row is written the
    // cycle right after its third beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
            pack     <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_en <= 1'b0;
            if (clear) begin
                beat_cnt <= '0;
            end else if (beat_valid) begin
                pack[(BEATS_PER_ROW - 1 - int'(beat_cnt)) * SLOT_W +: SLOT_W] <= beat_data;
                if (row_last) begin
                    beat_cnt <= '0;
                    wr_en    <= 1'b1;
                    wr_addr  <= row_addr;
                    wr_data  <= {pack[ROW_PIX*PIXEL_W-1:SLOT_W], beat_data};
                end else begin
                    beat_cnt <= beat_cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/fetch_ref_chroma_load.sv
// Chroma reference row-buffer fill: requests a search-window block from
// external memory and writes ROW_NUM packed rows into the row buffer.
module fetch_ref_chroma_load
    import fetch_ref_chroma_load_pkg::*;
#(
    parameter int PIXEL_W = 8,
    parameter int ROW_NUM = 48,
    parameter int ADDR_W  = 6
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          start_i,
    input  logic [7:0]                    sw_x_i,
    input  logic [7:0]                    sw_y_i,
    output logic                          ext_req_o,
    output logic [7:0]                    ext_x_o,
    output logic [7:0]                    ext_y_o,
    input  logic                          ext_ack_i,
    input  logic                          ext_valid_i,
    input  logic [BEAT_PIX*PIXEL_W-1:0]   ext_data_i,
    output logic                          wrif_en_o,
    output logic [ADDR_W-1:0]             wrif_addr_o,
    output logic [ROW_PIX*PIXEL_W-1:0]    wrif_data_o,
    output logic                          busy_o,
    output logic                          done_o
);

    // One extra counter bit lets ROW_NUM = 2**ADDR_W terminate without wrapping.
    localparam int               CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROW_NUM - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] row_cnt;
    logic             load_start;
    logic             beat_accept;
    logic             row_last;

    assign load_start  = (state == ST_IDLE) && start_i;
    assign beat_accept = (state == ST_LOAD) && ext_valid_i;

    assign ext_req_o = (state == ST_REQ);
    assign busy_o    = (state != ST_IDLE);
    assign done_o    = (state == ST_DONE);

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state   <= ST_IDLE;
            row_cnt <= '0;
            ext_x_o <= '0;
            ext_y_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        ext_x_o <= sw_x_i;
                        ext_y_o <= sw_y_i;
                        row_cnt <= '0;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ext_ack_i) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (row_last) begin
                        row_cnt <= row_cnt + CNT_W'(1);
                        if (row_cnt == LAST_ROW) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    fetch_row_packer #(
        .PIXEL_W (PIXEL_W),
        .ADDR_W  (ADDR_W)
    ) u_packer (
        .clk        (clk),
        .rst        (rstn),
        .clear      (load_start),
        .beat_valid (beat_accept),
        .beat_data  (ext_data_i),
        .row_addr   (row_cnt[ADDR_W-1:0]),
        .row_last   (row_last),
        .wr_en      (wrif_en_o),
        .wr_addr    (wrif_addr_o),
        .wr_data    (wrif_data_o)
    );

endmodule

// File: tb/tb_fetch_ref_chroma_load.sv
// Directed bench for fetch_ref_chroma_load with ROW_NUM = 48, 64 and 1
// instances sharing one stimulus stream.
module tb_fetch_ref_chroma_load;

    logic         clk;
    logic         rstn;
    logic         start_i;
    logic [7:0]   sw_x;
    logic [7:0]   sw_y;
    logic         ack;
    logic         valid;
    logic [127:0] data;

    logic         req   [3];
    logic [7:0]   ex    [3];
    logic [7:0]   ey    [3];
    logic         wen   [3];
    logic [5:0]   wad   [3];
    logic [383:0] wdt   [3];
    logic         busy  [3];
    logic         done  [3];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int beat_base = 0;
    int wcnt [3];
    int dcnt [3];
    int third_cyc [72];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fetch_ref_chroma_load #(
            .PIXEL_W (8),
            .ROW_NUM ((g == 0) ? 48 : ((g == 1) ? 64 : 1)),
            .ADDR_W  (6)
        ) dut (
            .clk         (clk),
            .rstn        (rstn),
            .start_i     (start_i),
            .sw_x_i      (sw_x),
            .sw_y_i      (sw_y),
            .ext_req_o   (req[g]),
            .ext_x_o     (ex[g]),
            .ext_y_o     (ey[g]),
            .ext_ack_i   (ack),
            .ext_valid_i (valid),
            .ext_data_i  (data),
            .wrif_en_o   (wen[g]),
            .wrif_addr_o (wad[g]),
            .wrif_data_o (wdt[g]),
            .busy_o      (busy[g]),
            .done_o      (done[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int rows_of(input int i);
        return (i == 0) ? 48 : ((i == 1) ? 64 : 1);
    endfunction

    function automatic logic [383:0] row_word(input int base, input int r);
        logic [383:0] w;
        logic [7:0]   p;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            p = 8'(base + 3 * r + i);
            w[(2 - i) * 128 +: 128] = {16{p}};
        end
        return w;
    endfunction

    task automatic chk(input string tag, input int idx, input logic [383:0] obs, input logic [383:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, idx, obs, exp);
        end
    endtask

    // Expected write/done for each instance follow from when the bench drove
    // each row's third beat.
    task automatic monitor();
        logic exp_wr;
        logic exp_done;
        for (int i = 0; i < 3; i++) begin
            exp_wr   = (wcnt[i] < rows_of(i)) && (third_cyc[wcnt[i]] + 1 == cyc);
            exp_done = (third_cyc[rows_of(i) - 1] + 1 == cyc);
            chk("wr_en", i, wen[i], exp_wr);
            chk("done", i, done[i], exp_done);
            if (exp_wr) begin
                chk("wr_addr", i, wad[i], wcnt[i]);
                chk("wr_data", i, wdt[i], row_word(beat_base, wcnt[i]));
                wcnt[i]++;
            end
            if (done[i] === 1'b1) dcnt[i]++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_data", i, wdt[i], '0);
            chk("rst_ctl", i, {req[i], ex[i], ey[i], wen[i], wad[i], busy[i], done[i]}, '0);
        end
        tick();
        tick();
        rstn = 1'b0;
        tick();
    endtask

    task automatic drive_beat(input int k);
        valid = 1'b1;
        data  = {16{8'(beat_base + k)}};
        if (k % 3 == 2) third_cyc[k / 3] = cyc;
        tick();
        valid = 1'b0;
    endtask

    task automatic run_load(input int base, input int x, input int y, input int nbeats,
                            input int gap, input bit noise, input bit one);
        int rows;
        beat_base = base;
        for (int i = 0; i < 3; i++) begin
            wcnt[i] = 0;
            dcnt[i] = 0;
        end
        for (int r = 0; r < 72; r++) third_cyc[r] = -10;
        if (noise) begin
            valid = 1'b1;
            data  = {16{8'hEE}};
            tick();
            valid = 1'b0;
        end
        sw_x = 8'(x);
        sw_y = 8'(y);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        sw_x = ~8'(x);
        sw_y = ~8'(y);
        for (int i = 0; i < 3; i++) begin
            chk("req_on", i, req[i], 1'b1);
            chk("ext_x", i, ex[i], x);
            chk("ext_y", i, ey[i], y);
            chk("busy_on", i, busy[i], 1'b1);
        end
        if (noise) begin
            valid = 1'b1;
            data  = {16{8'hEE}};
        end
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        valid = 1'b0;
        for (int i = 0; i < 3; i++) chk("req_off", i, req[i], 1'b0);
        for (int k = 0; k < nbeats; k++) begin
            repeat ($urandom_range(0, gap)) tick();
            if (one && k == 3) begin
                chk("one_done", 2, done[2], 1'b1);
                chk("one_busy", 2, busy[2], 1'b1);
            end
            if (one && k == 4) begin
                chk("one_done_end", 2, done[2], 1'b0);
                chk("one_busy_end", 2, busy[2], 1'b0);
            end
            if (noise && k == 1) begin
                start_i = 1'b1;
                sw_x = 8'(x + 7);
            end
            drive_beat(k);
            start_i = 1'b0;
        end
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            rows = (nbeats / 3 < rows_of(i)) ? nbeats / 3 : rows_of(i);
            chk("write_count", i, wcnt[i], rows);
            chk("done_count", i, dcnt[i], (nbeats / 3 >= rows_of(i)) ? 1 : 0);
            chk("busy_end", i, busy[i], (nbeats / 3 < rows_of(i)) ? 1'b1 : 1'b0);
            chk("ext_x_hold", i, ex[i], x);
            chk("ext_y_hold", i, ey[i], y);
        end
    endtask

    initial begin
        rstn = 1'b0;
        start_i = 1'b0;
        sw_x = '0;
        sw_y = '0;
        ack = 1'b0;
        valid = 1'b0;
        data = '0;
        for (int i = 0; i < 3; i++) begin
            wcnt[i] = 0;
            dcnt[i] = 0;
        end
        for (int r = 0; r < 72; r++) third_cyc[r] = -10;
        #1;
        do_reset();

        $display("[TB] basic load");
        run_load(0, 3, 5, 144, 0, 1'b0, 1'b1);

        $display("[TB] gapped beats");
        do_reset();
        run_load(0, 3, 5, 144, 5, 1'b0, 1'b0);

        $display("[TB] ignored inputs");
        do_reset();
        run_load(8'h40, 9, 200, 144, 1, 1'b1, 1'b0);

        $display("[TB] reset mid-load");
        do_reset();
        run_load(8'h80, 12, 34, 40, 0, 1'b0, 1'b0);
        do_reset();
        run_load(8'hC0, 1, 2, 144, 0, 1'b0, 1'b0);

        $display("[TB] full 64-row load with trailing beats");
        do_reset();
        run_load(8'h10, 255, 0, 198, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
